ahb_master_bridge: RTL and testbench
====================================

AHB_MASTER_BRIDGE -- requirements
Module: ahb_master_bridge

Interface
REQ-001 Parameter ALIGN_CHECK, default 1: when 1, misaligned requests complete with an error response and issue no AHB transfer.
REQ-002 hclk  in  1  clock; all state on rising edge.
REQ-003 hreset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  CPU request valid.
REQ-005 req_ready  out  1  bridge accepts request when req_valid&req_ready at a rising edge.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_size  in  2  0=byte, 1=halfword, 2=word, 3=illegal.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  write data, right-justified for byte/halfword.
REQ-010 rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-011 rsp_rdata  out  32  full 32-bit word read from bus, undefined for writes.
REQ-012 rsp_err  out  1  completion carried an error, valid with rsp_valid.
REQ-013 htrans  out  2  AHB transfer type, IDLE=00 or NONSEQ=10 only.
REQ-014 hwrite, hsize(3), haddr(32)  out  AHB address-phase controls.
REQ-015 hburst  out  3  constant 000 (SINGLE); hprot out 4 constant 0011.
REQ-016 hwdata  out  32  AHB write data, data phase.
REQ-017 hrdata  in  32; hready  in  1; hresp  in  2  AHB slave response.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one transfer outstanding at a time.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE + accepted legal request: register addr/write/size/wdata, go ADDR.
REQ-021 Illegal request (req_size=3, or ALIGN_CHECK=1 and size=1 with addr[0]=1 or size=2 with addr[1:0]!=0): stay IDLE, rsp_valid=1 and rsp_err=1 next cycle, htrans stays IDLE.
REQ-022 ADDR: htrans=NONSEQ, haddr/hwrite/hsize={0,size} from registers; all held stable while hready=0; go DATA at edge with hready=1.
REQ-023 Outside ADDR: htrans=IDLE; haddr/hwrite/hsize hold last values.
REQ-024 DATA: hwdata driven from registered data, replicated per size: byte {4{d[7:0]}}, halfword {2{d[15:0]}}, word d; held stable while hready=0.
REQ-025 DATA + hready=1: capture hrdata into rsp_rdata, rsp_err=(hresp!=00), rsp_valid=1 next cycle, go IDLE.
REQ-026 hresp RETRY/SPLIT treated as error; hresp ignored while hready=0 (first ERROR cycle does not end transfer).
REQ-027 rsp_valid is a single-cycle pulse; req_ready=1 in that cycle, allowing back-to-back requests; zero-wait throughput one transfer per 3 cycles.
REQ-028 Zero-wait latency: accept edge E0, address phase E0..E1, data phase E1..E2, rsp_valid high E2..E3.
REQ-029 Each hready=0 cycle in ADDR or DATA adds exactly one cycle of latency.
REQ-030 req_valid or req_* changes outside IDLE SHALL be ignored.

Reset
REQ-031 hreset_n low: state=IDLE, htrans=00, hwrite=0, hsize=0, haddr=0, hwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 after release.
REQ-032 Reset mid-transfer aborts immediately with no rsp_valid; first post-reset request behaves as from cold reset.

Verification
REQ-033 Word write addr 0x10 data 0xA5A5_1234, hready=1 -> NONSEQ/hwrite=1/hsize=2 one cycle, hwdata=0xA5A5_1234 next, rsp_valid at E2, rsp_err=0.
REQ-034 Byte write addr 0x13 data 0x77 then word read 0x10 from ahb_ram -> hwdata=0x7777_7777, read rsp_rdata[31:24]=0x77.
REQ-035 Read with 2 hready=0 cycles in DATA -> hwdata/haddr stable, rsp_valid exactly 2 cycles later than zero-wait case.
REQ-036 Two-cycle ERROR (hready=0/hresp=01 then hready=1/hresp=01) -> single rsp_valid with rsp_err=1, FSM back to IDLE.
REQ-037 Word request addr 0x2 (ALIGN_CHECK=1), and req_size=3 -> rsp_err=1 next cycle, htrans never NONSEQ.
REQ-038 hreset_n low during DATA -> htrans=00, rsp_valid never pulses; next request completes normally.

Source files
------------

// File: rtl/ahb_master_bridge.sv
// CPU-request to AHB-Lite single-transfer master bridge.
// One transfer in flight at a time; completions return as a one-cycle rsp_valid pulse.
module ahb_master_bridge #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] haddr,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic bad;
    bad = (size == 2'd3);
    if (ALIGN_CHECK) begin
      if (size == 2'd1 && addr_lsb[0])
        bad = 1'b1;
      if (size == 2'd2 && addr_lsb != 2'b00)
        bad = 1'b1;
    end
    return bad;
  endfunction

  // Narrow writes are replicated across all byte lanes so the slave can pick any lane.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    hwdata_d    = hwdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (is_illegal(req_size, req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            haddr_d  = req_addr;
            hwrite_d = req_write;
            size_d   = req_size;
            wdata_d  = req_wdata;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (hready) begin
          hwdata_d = replicate(size_q, wdata_q);
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        // hresp only counts on the completing cycle; RETRY/SPLIT are reported as errors.
        if (hready) begin
          rdata_d     = hrdata;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (hresp != 2'b00);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      hwdata_q    <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign htrans    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = {1'b0, size_q};
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Directed table-driven bench for ahb_master_bridge with a small word memory acting as the AHB slave.
module tb_ahb_master_bridge;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  ahb_master_bridge #(.ALIGN_CHECK(1'b1)) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .haddr     (haddr),
    .hburst    (hburst),
    .hprot     (hprot),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    logic [1:0]  wait_resp;
    logic [1:0]  fin_resp;
    int          lat;
    logic        err;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] mem[16];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cur_vec = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h at %0t", cur_vec, name, act, exp, $time);
    end
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    int i;
    int lane;
    i = int'(addr[5:2]);
    case (size)
      2'd0: begin
        lane = int'(addr[1:0]);
        mem[i][8*lane +: 8] = data[8*lane +: 8];
      end
      2'd1: begin
        lane = int'(addr[1]);
        mem[i][16*lane +: 16] = data[16*lane +: 16];
      end
      default: mem[i] = data;
    endcase
  endtask

  task automatic run_vec(input vec_t v);
    int  j;
    logic fin;
    @(negedge hclk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    hready    = 1'b1;
    hresp     = 2'b00;
    hrdata    = 32'hDEAD_BEEF;
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge hclk);
      if (k == v.lat) begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(v.err));
        chk("rsp_ready", 32'(req_ready), 32'd1);
        chk("rsp_htrans", 32'(htrans), 32'd0);
        if (!v.wr && !v.err)
          chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        req_valid = 1'b0;
        hready    = 1'b1;
        hresp     = 2'b00;
        hrdata    = 32'hDEAD_BEEF;
      end else begin
        chk("no_rsp", 32'(rsp_valid), 32'd0);
        chk("busy_ready", 32'(req_ready), 32'd0);
        // Garbage on the request port while busy must be ignored.
        req_valid = 1'b1;
        req_write = ~v.wr;
        req_size  = 2'd3;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        if (k <= 1 + v.aw) begin
          chk("addr_htrans", 32'(htrans), 32'd2);
          chk("addr_haddr", haddr, v.addr);
          chk("addr_hwrite", 32'(hwrite), 32'(v.wr));
          chk("addr_hsize", 32'(hsize), 32'(v.size));
          hready = (k == 1 + v.aw);
          hresp  = 2'b00;
        end else begin
          j = k - 2 - v.aw;
          fin = (j == v.dw);
          chk("data_htrans", 32'(htrans), 32'd0);
          chk("data_haddr", haddr, v.addr);
          if (v.wr)
            chk("data_hwdata", hwdata, v.exp_hwdata);
          hready = fin;
          hresp  = fin ? v.fin_resp : v.wait_resp;
          hrdata = fin ? mem[int'(v.addr[5:2])] : 32'hDEAD_BEEF;
          if (fin && v.wr && !v.err)
            mem_write(v.addr, v.size, hwdata);
        end
      end
    end
    @(negedge hclk);
    chk("pulse_end", 32'(rsp_valid), 32'd0);
    chk("after_htrans", 32'(htrans), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //         wr    sz    addr          wdata         aw dw wresp fresp lat err exp_hwdata    exp_rdata
    vecs[0]  = '{1'b1, 2'd2, 32'h0000_0010, 32'hA5A5_1234, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'hA5A5_1234, 32'h0};
    vecs[1]  = '{1'b1, 2'd0, 32'h0000_0013, 32'h0000_0077, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h7777_7777, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0,         32'h77A5_1234};
    vecs[3]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         0, 2, 2'b00, 2'b00, 5, 1'b0, 32'h0,         32'h77A5_1234};
    vecs[4]  = '{1'b1, 2'd1, 32'h0000_0022, 32'h0000_BEEF, 1, 0, 2'b00, 2'b00, 4, 1'b0, 32'hBEEF_BEEF, 32'h0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         1, 1, 2'b00, 2'b00, 5, 1'b0, 32'h0,         32'hBEEF_0000};
    vecs[6]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         0, 1, 2'b01, 2'b01, 4, 1'b1, 32'h0,         32'h0};
    vecs[7]  = '{1'b0, 2'd1, 32'h0000_0020, 32'h0,         0, 0, 2'b00, 2'b10, 3, 1'b1, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         0, 2, 2'b01, 2'b00, 5, 1'b0, 32'h0,         32'hBEEF_0000};
    vecs[9]  = '{1'b1, 2'd2, 32'h0000_0002, 32'h1111_1111, 0, 0, 2'b00, 2'b00, 1, 1'b1, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0,         0, 0, 2'b00, 2'b00, 1, 1'b1, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 2'd1, 32'h0000_0021, 32'h0,         0, 0, 2'b00, 2'b00, 1, 1'b1, 32'h0,         32'h0};
    vecs[12] = '{1'b1, 2'd0, 32'h0000_0021, 32'h1234_5601, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0101_0101, 32'h0};
    vecs[13] = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0,         32'hBEEF_0100};
    vecs[14] = '{1'b0, 2'd1, 32'h0000_0022, 32'h0,         0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0,         32'hBEEF_0100};
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    hreset_n  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    hready    = 1'b1;
    hresp     = 2'b00;
    hrdata    = 32'h0;
    repeat (3) @(negedge hclk);
    hreset_n = 1'b1;
    @(negedge hclk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'd0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("hburst", 32'(hburst), 32'd0);
    chk("hprot", 32'(hprot), 32'd3);

    for (int i = 0; i < 15; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Back-to-back: a new request accepted in the response cycle.
    cur_vec = 100;
    @(negedge hclk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_addr = 32'h30; req_wdata = 32'h1122_3344; hready = 1'b1; hresp = 2'b00;
    @(negedge hclk);
    chk("b2b_w_htrans", 32'(htrans), 32'd2);
    chk("b2b_w_haddr", haddr, 32'h30);
    req_valid = 1'b0;
    @(negedge hclk);
    chk("b2b_w_hwdata", hwdata, 32'h1122_3344);
    @(negedge hclk);
    chk("b2b_w_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_w_err", 32'(rsp_err), 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h30;
    @(negedge hclk);
    chk("b2b_r_htrans", 32'(htrans), 32'd2);
    chk("b2b_r_hwrite", 32'(hwrite), 32'd0);
    chk("b2b_r_norsp", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge hclk);
    chk("b2b_r_data_htrans", 32'(htrans), 32'd0);
    hrdata = 32'h1122_3344;
    @(negedge hclk);
    chk("b2b_r_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_r_rdata", rsp_rdata, 32'h1122_3344);
    hrdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    chk("b2b_pulse_end", 32'(rsp_valid), 32'd0);

    // Reset asserted in the data phase aborts without a response.
    cur_vec = 101;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_addr = 32'h44; req_wdata = 32'hCAFE_F00D;
    @(negedge hclk);
    chk("rst_mid_htrans", 32'(htrans), 32'd2);
    req_valid = 1'b0;
    @(negedge hclk);
    chk("rst_mid_hwdata", hwdata, 32'hCAFE_F00D);
    hready = 1'b0;
    hreset_n = 1'b0;
    #1;
    chk("rst_mid_htrans0", 32'(htrans), 32'd0);
    chk("rst_mid_hwdata0", hwdata, 32'h0);
    chk("rst_mid_haddr0", haddr, 32'h0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      chk("rst_hold_rsp", 32'(rsp_valid), 32'd0);
    end
    hreset_n = 1'b1;
    hready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_htrans", 32'(htrans), 32'd0);
    end
    cur_vec = 102;
    run_vec('{1'b1, 2'd2, 32'h0000_0048, 32'h0BAD_C0DE, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0BAD_C0DE, 32'h0});
    cur_vec = 103;
    run_vec('{1'b0, 2'd2, 32'h0000_0048, 32'h0, 0, 0, 2'b00, 2'b00, 3, 1'b0, 32'h0, 32'h0BAD_C0DE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
